// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update controller.
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_update_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } bp_ctrl_state_e;

    localparam logic [31:0] PC_INC_RVC  = 32'd2;
    localparam logic [31:0] PC_INC_RV32 = 32'd4;

endpackage

// File: rtl/bp_upd_fifo.sv
// Training-update queue: synchronous FIFO of bp_update_t entries.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  bp_update_t  push_data,
    input  logic        pop,
    output bp_update_t  head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    bp_update_t    mem_q [DEPTH];
    bp_update_t    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch predictor update controller: mispredict redirect, training queue drain,
// fence handshake and saturating branch statistics.
//
//  state | meaning
//  RUN   | accepting resolution records, draining training in background
//  DRAIN | fence in progress, no new records, draining until queue empty
//  ACK   | queue empty, fence_ack pulses this cycle, back to RUN next
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STAT_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [31:0]                 res_pc,
    input  logic                        res_is_rvc,
    input  logic                        res_is_cti,
    input  logic                        res_taken,
    input  logic [31:0]                 res_target,
    input  logic                        res_pred_taken,
    input  logic                        res_pred_valid,
    input  logic [31:0]                 res_pred_target,
    input  logic                        train_en,
    output logic                        redirect_valid,
    output logic [31:0]                 redirect_pc,
    output logic                        upd_en,
    output logic [31:0]                 upd_pc,
    output logic                        upd_taken,
    output logic [31:0]                 upd_target,
    input  logic                        upd_stall,
    input  logic                        fence_req,
    output logic                        fence_ack,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [STAT_W-1:0]           stat_branches,
    output logic [STAT_W-1:0]           stat_mispredicts
);

    bp_ctrl_state_e    state_q, state_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [STAT_W-1:0] stat_br_q, stat_br_d;
    logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

    logic       pred_eff;
    logic       mispredict;
    logic       accept;
    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    bp_update_t fifo_head;
    bp_update_t push_entry;

    assign pred_eff   = res_pred_taken && res_pred_valid;
    assign mispredict = res_is_cti &&
                        ((res_taken != pred_eff) ||
                         (res_taken && pred_eff && (res_target != res_pred_target)));
    assign accept     = res_valid && res_ready;
    assign fifo_push  = accept && res_is_cti && train_en;
    assign push_entry = '{pc: res_pc, taken: res_taken, target: res_target};

    bp_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (upd_en),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign upd_en     = !fifo_empty && !upd_stall;
    assign upd_pc     = fifo_empty ? '0   : fifo_head.pc;
    assign upd_taken  = fifo_empty ? 1'b0 : fifo_head.taken;
    assign upd_target = fifo_empty ? '0   : fifo_head.target;

    // Ready looks at fence_req combinationally so a record presented in the
    // same cycle as the fence request is refused.
    always_comb begin
        state_d   = state_q;
        res_ready = 1'b0;
        fence_ack = 1'b0;
        case (state_q)
            RUN: begin
                res_ready = !fence_req && !fifo_full;
                if (fence_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                fence_ack = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        redirect_valid_d = accept && mispredict;
        redirect_pc_d    = '0;
        if (accept && mispredict) begin
            redirect_pc_d = res_taken ? res_target
                                      : res_pc + (res_is_rvc ? PC_INC_RVC : PC_INC_RV32);
        end
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (accept && res_is_cti && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + STAT_W'(1);
        end
        if (accept && mispredict && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stat_br_q        <= '0;
            stat_mp_q        <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stat_br_q        <= stat_br_d;
            stat_mp_q        <= stat_mp_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: vector table, directed fence and
// backpressure sequences, and a randomized run against a queue-based model.
module tb_bp_update_ctrl;

    localparam int DEPTH = 4;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          res_valid, res_ready, res_is_rvc, res_is_cti, res_taken;
    logic          res_pred_taken, res_pred_valid, train_en;
    logic [31:0]   res_pc, res_target, res_pred_target;
    logic          redirect_valid, upd_en, upd_taken, upd_stall, fence_req, fence_ack;
    logic [31:0]   redirect_pc, upd_pc, upd_target;
    logic [2:0]    fifo_level;
    logic [SW-1:0] stat_branches, stat_mispredicts;

    bp_update_ctrl #(.FIFO_DEPTH(DEPTH), .STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_is_rvc(res_is_rvc), .res_is_cti(res_is_cti), .res_taken(res_taken),
        .res_target(res_target), .res_pred_taken(res_pred_taken),
        .res_pred_valid(res_pred_valid), .res_pred_target(res_pred_target),
        .train_en(train_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_stall(upd_stall), .fence_req(fence_req), .fence_ack(fence_ack),
        .fifo_level(fifo_level), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        rvc, cti, taken;
        logic [31:0] target;
        logic        pt, pv;
        logic [31:0] ptarget;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        int          exp_br, exp_mp;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    function automatic vec_t mk(logic [31:0] pc, logic rvc, logic cti, logic taken,
                                logic [31:0] target, logic pt, logic pv, logic [31:0] ptarget,
                                logic exp_redir, logic [31:0] exp_rpc, int exp_br, int exp_mp);
        vec_t v;
        v.pc = pc; v.rvc = rvc; v.cti = cti; v.taken = taken; v.target = target;
        v.pt = pt; v.pv = pv; v.ptarget = ptarget; v.exp_redir = exp_redir;
        v.exp_rpc = exp_rpc; v.exp_br = exp_br; v.exp_mp = exp_mp;
        return v;
    endfunction

    function automatic logic ref_misp(logic cti, logic taken, logic pt, logic pv,
                                      logic [31:0] tgt, logic [31:0] ptgt);
        logic pe;
        pe = pt && pv;
        return cti && ((taken != pe) || (taken && pe && tgt != ptgt));
    endfunction

    task automatic idle();
        res_valid = 0; res_pc = '0; res_is_rvc = 0; res_is_cti = 0; res_taken = 0;
        res_target = '0; res_pred_taken = 0; res_pred_valid = 0; res_pred_target = '0;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        res_valid = 1; res_pc = pc; res_is_rvc = 0; res_is_cti = 1; res_taken = taken;
        res_target = tgt; res_pred_taken = taken; res_pred_valid = 1; res_pred_target = tgt;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    vec_t        vecs[8];
    ent_t        mq[$];
    logic [31:0] got_pc[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        int acks;
        logic [SW-1:0] br_before;
        int unsigned br, mp;
        logic er_v, acc, exp_ready, exp_upd, m;
        logic [31:0] er_pc;

        vecs[0] = mk(32'h100, 0, 1, 0, 32'h150, 0, 0, 32'h0,   0, 32'h0,   1, 0);
        vecs[1] = mk(32'h200, 1, 1, 0, 32'h280, 1, 1, 32'h280, 1, 32'h202, 2, 1);
        vecs[2] = mk(32'h380, 0, 1, 1, 32'h400, 1, 1, 32'h480, 1, 32'h400, 3, 2);
        vecs[3] = mk(32'h500, 0, 1, 1, 32'h300, 1, 0, 32'h300, 1, 32'h300, 4, 3);
        vecs[4] = mk(32'h600, 0, 1, 1, 32'h700, 1, 1, 32'h700, 0, 32'h0,   5, 3);
        vecs[5] = mk(32'h610, 0, 0, 1, 32'h900, 0, 0, 32'h0,   0, 32'h0,   5, 3);
        vecs[6] = mk(32'hFFFF_FFFE, 0, 1, 0, 32'h10, 1, 1, 32'h10, 1, 32'h2, 6, 4);
        vecs[7] = mk(32'h720, 1, 1, 0, 32'h800, 1, 0, 32'h800, 0, 32'h0,   7, 4);

        idle(); upd_stall = 0; fence_req = 0; train_en = 1; rst_n = 0;
        #3;
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_upd_en", upd_en, 0);
        chk("rst_fence_ack", fence_ack, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_stat_br", stat_branches, 0);
        chk("rst_stat_mp", stat_mispredicts, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_ready", res_ready, 1);

        // Vector table: each record drained the cycle after it is accepted.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            res_valid = 1; res_pc = vecs[i].pc; res_is_rvc = vecs[i].rvc;
            res_is_cti = vecs[i].cti; res_taken = vecs[i].taken; res_target = vecs[i].target;
            res_pred_taken = vecs[i].pt; res_pred_valid = vecs[i].pv;
            res_pred_target = vecs[i].ptarget;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), res_ready, 1);
            @(posedge clk); #1;
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d_redirect_valid", i), redirect_valid, vecs[i].exp_redir);
            if (vecs[i].exp_redir) chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
            chk($sformatf("vec%0d_upd_en", i), upd_en, vecs[i].cti);
            if (vecs[i].cti) begin
                chk($sformatf("vec%0d_upd_pc", i), upd_pc, vecs[i].pc);
                chk($sformatf("vec%0d_upd_taken", i), upd_taken, vecs[i].taken);
                chk($sformatf("vec%0d_upd_target", i), upd_target, vecs[i].target);
            end
            chk($sformatf("vec%0d_stat_br", i), stat_branches, vecs[i].exp_br);
            chk($sformatf("vec%0d_stat_mp", i), stat_mispredicts, vecs[i].exp_mp);
        end

        // Backpressure: 5 records against a stalled predictor.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            upd_stall = 1;
            set_rec(32'h1000 + 32'(16 * i), i[0], 32'h2000 + 32'(i));
            @(negedge clk);
            chk($sformatf("bp_ready%0d", i), res_ready, 1);
        end
        @(posedge clk); #1;
        set_rec(32'h1040, 0, 32'h2004);
        @(negedge clk);
        chk("bp_full_ready", res_ready, 0);
        chk("bp_full_level", fifo_level, 4);
        chk("bp_full_upd_en", upd_en, 0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_hold_ready", res_ready, 0);
            chk("bp_hold_level", fifo_level, 4);
        end
        @(posedge clk); #1;
        upd_stall = 0;
        @(negedge clk);
        chk("bp_rel_upd_en0", upd_en, 1);
        chk("bp_rel_upd_pc0", upd_pc, 32'h1000);
        chk("bp_rel_ready0", res_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_rel_upd_pc1", upd_pc, 32'h1010);
        chk("bp_rel_ready1", res_ready, 1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("bp_rel_level_after_push_pop", fifo_level, 3);
        for (int k = 2; k < 5; k++) begin
            chk($sformatf("bp_rel_upd_en%0d", k), upd_en, 1);
            chk($sformatf("bp_rel_upd_pc%0d", k), upd_pc, 32'h1000 + 32'(16 * k));
            chk($sformatf("bp_rel_upd_target%0d", k), upd_target, 32'h2000 + 32'(k));
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk("bp_drained_upd_en", upd_en, 0);
        chk("bp_drained_upd_pc", upd_pc, 0);

        // Fence with three queued entries.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            upd_stall = 1;
            set_rec(32'h3000 + 32'(4 * i), 1, 32'h3800 + 32'(i));
        end
        @(posedge clk); #1;
        set_rec(32'h3FFC, 1, 32'h3FF0);
        fence_req = 1; upd_stall = 0;
        br_before = stat_branches;
        acks = 0;
        got_pc.delete();
        for (int c = 0; c < 20 && acks == 0; c++) begin
            @(negedge clk);
            chk("fence_ready_low", res_ready, 0);
            if (upd_en) got_pc.push_back(upd_pc);
            if (fence_ack) acks++;
            @(posedge clk); #1;
        end
        fence_req = 0; idle();
        chk("fence_ack_seen", acks, 1);
        chk("fence_upd_count", got_pc.size(), 3);
        for (int i = 0; i < 3 && i < got_pc.size(); i++)
            chk($sformatf("fence_upd_pc%0d", i), got_pc[i], 32'h3000 + 32'(4 * i));
        @(negedge clk);
        chk("fence_ack_single", fence_ack, 0);
        chk("fence_resume_ready", res_ready, 1);
        chk("fence_no_accept", stat_branches, br_before);

        // Fence with an empty queue: ack two cycles after request.
        @(posedge clk); #1;
        fence_req = 1;
        @(negedge clk);
        chk("efence_c0", fence_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("efence_c1", fence_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("efence_c2", fence_ack, 1);
        @(posedge clk); #1;
        fence_req = 0;
        @(negedge clk);
        chk("efence_c3", fence_ack, 0);
        chk("efence_ready", res_ready, 1);

        // Reset during DRAIN discards queue and fence.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            upd_stall = 1;
            set_rec(32'h5000 + 32'(4 * i), 0, 32'h0);
        end
        @(posedge clk); #1;
        idle(); fence_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rdrain_level_pre", fifo_level, 3);
        #2 rst_n = 0;
        #1;
        chk("rdrain_level", fifo_level, 0);
        chk("rdrain_upd_en", upd_en, 0);
        chk("rdrain_ack", fence_ack, 0);
        fence_req = 0;
        @(posedge clk); #1;
        rst_n = 1; upd_stall = 0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (fence_ack) acks++;
            @(posedge clk); #1;
        end
        chk("rdrain_no_ack", acks, 0);
        chk("rdrain_level_post", fifo_level, 0);
        chk("rdrain_ready_post", res_ready, 1);

        // Randomized run against a queue-based model.
        do_reset();
        mq.delete(); br = 0; mp = 0; er_v = 0; er_pc = '0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            res_valid       = ($urandom_range(0, 9) < 7);
            upd_stall       = ($urandom_range(0, 9) < 3);
            train_en        = ($urandom_range(0, 9) < 8);
            res_is_cti      = ($urandom_range(0, 9) < 8);
            res_is_rvc      = 1'($urandom_range(0, 1));
            res_taken       = 1'($urandom_range(0, 1));
            res_pred_taken  = 1'($urandom_range(0, 1));
            res_pred_valid  = 1'($urandom_range(0, 1));
            res_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                            : $urandom;
            res_target      = $urandom;
            res_pred_target = $urandom_range(0, 1) ? res_target : $urandom;
            @(negedge clk);
            exp_ready = (mq.size() < DEPTH);
            exp_upd   = (mq.size() > 0) && !upd_stall;
            chk("rnd_ready", res_ready, exp_ready);
            chk("rnd_upd_en", upd_en, exp_upd);
            chk("rnd_level", fifo_level, mq.size());
            if (mq.size() > 0) begin
                if (exp_upd) begin
                    chk("rnd_upd_pc", upd_pc, mq[0].pc);
                    chk("rnd_upd_taken", upd_taken, mq[0].taken);
                    chk("rnd_upd_target", upd_target, mq[0].target);
                end
            end else begin
                chk("rnd_upd_pc_empty", upd_pc, 0);
            end
            chk("rnd_redirect_valid", redirect_valid, er_v);
            if (er_v) chk("rnd_redirect_pc", redirect_pc, er_pc);
            chk("rnd_stat_br", stat_branches, br);
            chk("rnd_stat_mp", stat_mispredicts, mp);

            acc = res_valid && exp_ready;
            m   = ref_misp(res_is_cti, res_taken, res_pred_taken, res_pred_valid,
                           res_target, res_pred_target);
            if (exp_upd) void'(mq.pop_front());
            if (acc && res_is_cti) begin
                if (br < 255) br++;
                if (m && mp < 255) mp++;
                if (train_en) mq.push_back('{pc: res_pc, taken: res_taken, target: res_target});
            end
            er_v  = acc && m;
            er_pc = res_taken ? res_target : res_pc + (res_is_rvc ? 32'd2 : 32'd4);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
